// File: rtl/rca_arith_pkg.sv
// ---------------------------------------------------------------------------
// rca_arith_pkg
// Shared definitions for the sequential arithmetic blocks (rca_mult, rca_div
// and their future siblings).
//   arith_state_e  : IDLE / RUN / DONE control state of a start/done engine
//   DATA_WIDTH_DEF : default operand width
//   CNT_W_DEF      : step-counter width for the default operand width
//   cnt_width()    : step-counter width for an arbitrary operand width
// ---------------------------------------------------------------------------
package rca_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } arith_state_e;

  localparam int DATA_WIDTH_DEF = 32;

  // The counter must be able to hold the value W, hence W+1 codes.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W_DEF = $clog2(DATA_WIDTH_DEF + 1);

endpackage

// File: rtl/rca_div_if.sv
// ---------------------------------------------------------------------------
// rca_div_if
// Start/done handshake and operand/result bus of the restoring divider.
//   in_div_start      : request, sampled only when the divider is IDLE or DONE
//   in_div_dividend   : 2*DATA_WIDTH-bit unsigned dividend
//   in_div_divisor    : DATA_WIDTH-bit unsigned divisor
//   out_div_busy      : high while the divider is iterating
//   out_div_done      : one-cycle pulse, results valid
//   out_div_quotient  : DATA_WIDTH-bit quotient, held
//   out_div_remainder : DATA_WIDTH-bit remainder, held
//   out_div_err       : divide-by-zero / quotient overflow, held with results
// Modports: master drives the request side, slave is the divider.
// ---------------------------------------------------------------------------
interface rca_div_if #(
  parameter int DATA_WIDTH = 32
);

  logic                      in_div_start;
  logic [2*DATA_WIDTH-1:0]   in_div_dividend;
  logic [DATA_WIDTH-1:0]     in_div_divisor;
  logic                      out_div_busy;
  logic                      out_div_done;
  logic [DATA_WIDTH-1:0]     out_div_quotient;
  logic [DATA_WIDTH-1:0]     out_div_remainder;
  logic                      out_div_err;

  modport master (
    output in_div_start, in_div_dividend, in_div_divisor,
    input  out_div_busy, out_div_done, out_div_quotient,
           out_div_remainder, out_div_err
  );

  modport slave (
    input  in_div_start, in_div_dividend, in_div_divisor,
    output out_div_busy, out_div_done, out_div_quotient,
           out_div_remainder, out_div_err
  );

endinterface

// File: rtl/rca_div_step.sv
// ---------------------------------------------------------------------------
// rca_div_step
// One combinational restoring-division step: shift the partial remainder
// left by one, bring in the next dividend bit, and subtract the divisor if
// it fits.
//   i_rem     : DATA_WIDTH+1-bit partial remainder
//   i_bit     : next dividend bit shifted in at the LSB
//   i_divisor : DATA_WIDTH-bit divisor
//   o_rem     : next partial remainder
//   o_q       : quotient bit produced by this step
// ---------------------------------------------------------------------------
module rca_div_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH:0]   i_rem,
  input  logic                  i_bit,
  input  logic [DATA_WIDTH-1:0] i_divisor,
  output logic [DATA_WIDTH:0]   o_rem,
  output logic                  o_q
);

  logic [DATA_WIDTH:0] w_shift;
  logic [DATA_WIDTH:0] w_diff;

  // NOTE: every signal written in this always_comb is assigned on every path,
  // so no latch can be inferred.
  always_comb begin
    // The incoming remainder is always below the divisor, so its bit W is
    // zero and the shifted value fits in W+1 bits without loss.
    w_shift = {i_rem[DATA_WIDTH-1:0], i_bit};
    w_diff  = w_shift - {1'b0, i_divisor};
    o_q     = (w_shift >= {1'b0, i_divisor});
    o_rem   = o_q ? w_diff : w_shift;
  end

endmodule

// File: rtl/rca_div.sv
// ---------------------------------------------------------------------------
// rca_div
// Sequential restoring divider: 2*DATA_WIDTH-bit dividend by DATA_WIDTH-bit
// divisor, one quotient bit per clock, start/done handshake.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : rca_div_if.slave (start, operands, busy, done, results, err)
// Compile-time option:
//   RCA_DIV_ERR_CHECK_EN - when defined, a zero divisor or a quotient that
//   would not fit in DATA_WIDTH bits is flagged at start and the divider
//   goes straight to DONE with quotient all ones, remainder = dividend low
//   half and err set. When undefined, every start runs the full W steps and
//   err stays 0.
// ---------------------------------------------------------------------------
module rca_div
  import rca_arith_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input logic     clk,
  input logic     rst_n,
  rca_div_if.slave bus
);

  localparam int                CNT_W     = cnt_width(DATA_WIDTH);
  localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(DATA_WIDTH - 1);

  arith_state_e          r_state;
  logic [DATA_WIDTH:0]   r_rem;      // partial remainder, with carry bit
  logic [DATA_WIDTH-1:0] r_sreg;     // dividend low half in, quotient out
  logic [DATA_WIDTH-1:0] r_divisor;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_quot;
  logic [DATA_WIDTH-1:0] r_rem_out;

  logic [DATA_WIDTH:0]   w_rem_next;
  logic                  w_q_bit;
  logic [DATA_WIDTH-1:0] w_div_hi;
  logic [DATA_WIDTH-1:0] w_div_lo;
  logic                  w_fast_path;

  assign w_div_hi = bus.in_div_dividend[2*DATA_WIDTH-1:DATA_WIDTH];
  assign w_div_lo = bus.in_div_dividend[DATA_WIDTH-1:0];

`ifdef RCA_DIV_ERR_CHECK_EN
  // The quotient fits in W bits only when the dividend high half is below
  // the divisor; this also covers divisor == 0.
  assign w_fast_path = (bus.in_div_divisor == '0) ||
                       (w_div_hi >= bus.in_div_divisor);
`else
  assign w_fast_path = 1'b0;
`endif

  rca_div_step #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_step (
    .i_rem     (r_rem),
    .i_bit     (r_sreg[DATA_WIDTH-1]),
    .i_divisor (r_divisor),
    .o_rem     (w_rem_next),
    .o_q       (w_q_bit)
  );

  // NOTE: state is updated with non-blocking assignments only, so every
  // right-hand side sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_rem     <= '0;
      r_sreg    <= '0;
      r_divisor <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_quot    <= '0;
      r_rem_out <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (bus.in_div_start) begin
            if (w_fast_path) begin
              r_state   <= DONE;
              r_done    <= 1'b1;
              r_err     <= 1'b1;
              r_quot    <= '1;
              r_rem_out <= w_div_lo;
            end else begin
              r_state   <= RUN;
              r_busy    <= 1'b1;
              r_rem     <= {1'b0, w_div_hi};
              r_sreg    <= w_div_lo;
              r_divisor <= bus.in_div_divisor;
              r_cnt     <= '0;
            end
          end else begin
            r_state <= IDLE;
          end
        end

        RUN: begin
          // Start is not looked at here: a running operation cannot be
          // disturbed by the requester.
          r_rem  <= w_rem_next;
          r_sreg <= {r_sreg[DATA_WIDTH-2:0], w_q_bit};
          r_cnt  <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_STEP) begin
            r_state   <= DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_err     <= 1'b0;
            r_quot    <= {r_sreg[DATA_WIDTH-2:0], w_q_bit};
            r_rem_out <= w_rem_next[DATA_WIDTH-1:0];
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.out_div_busy      = r_busy;
  assign bus.out_div_done      = r_done;
  assign bus.out_div_quotient  = r_quot;
  assign bus.out_div_remainder = r_rem_out;
  assign bus.out_div_err       = r_err;

endmodule

// File: tb/tb_rca_div.sv
// ---------------------------------------------------------------------------
// tb_rca_div
// Self-checking bench for rca_div (DATA_WIDTH = 32): a table of directed
// vectors with hand-computed results, hand-written sequences for start
// during RUN, back-to-back starts and reset mid-RUN, and a sweep of
// operands built as q*d+r with r < d. Error-path vectors are included only
// when RCA_DIV_ERR_CHECK_EN is defined.
// ---------------------------------------------------------------------------
module tb_rca_div;

  localparam int W   = 32;
  localparam int LAT = W + 1;  // negedges from start edge to done sample

  typedef struct {
    string       name;
    logic [63:0] dividend;
    logic [31:0] divisor;
    logic [31:0] q;
    logic [31:0] r;
    logic        err;
    int          lat;
    logic        chk_qr;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  rca_div_if #(.DATA_WIDTH(W)) bus ();

  rca_div #(.DATA_WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic vec_t mk(input string name, input logic [63:0] dvd,
                              input logic [31:0] dvs, input logic [31:0] q,
                              input logic [31:0] r, input logic err,
                              input int lat, input logic chk_qr);
    vec_t v;
    v.name = name; v.dividend = dvd; v.divisor = dvs; v.q = q; v.r = r;
    v.err = err; v.lat = lat; v.chk_qr = chk_qr;
    return v;
  endfunction

  // One-cycle start pulse; returns just after the accepting edge (t0).
  task automatic drive_start(input logic [63:0] dvd, input logic [31:0] dvs);
    @(negedge clk);
    bus.in_div_dividend = dvd;
    bus.in_div_divisor  = dvs;
    bus.in_div_start    = 1'b1;
    @(posedge clk);
    #1 bus.in_div_start = 1'b0;
  endtask

  // Waits (bounded) for done; lat counts negedges, busy_cnt the busy samples
  // seen before done.
  task automatic wait_done(output logic seen, output int lat,
                           output int busy_cnt);
    seen = 1'b0; lat = 0; busy_cnt = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (bus.out_div_busy) busy_cnt++;
      if (bus.out_div_done) begin
        seen = 1'b1;
        lat  = k;
        break;
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic seen;
    int   lat, busy_cnt;
    drive_start(v.dividend, v.divisor);
    wait_done(seen, lat, busy_cnt);
    check({v.name, "/done_seen"}, 64'(seen), 64'(1));
    check({v.name, "/latency"}, 64'(lat), 64'(v.lat));
    check({v.name, "/busy_cycles"}, 64'(busy_cnt), 64'(v.lat - 1));
    check({v.name, "/err"}, 64'(bus.out_div_err), 64'(v.err));
    if (v.chk_qr) begin
      check({v.name, "/quotient"}, 64'(bus.out_div_quotient), 64'(v.q));
      check({v.name, "/remainder"}, 64'(bus.out_div_remainder), 64'(v.r));
    end
    @(negedge clk);
    check({v.name, "/done_width"}, 64'(bus.out_div_done), 64'(0));
  endtask

  initial begin
    logic        seen;
    int          lat, busy_cnt, done_cnt;
    logic [31:0] rq, rd, rr;

    vecs.push_back(mk("100_div_7", 64'd100, 32'd7, 32'd14, 32'd2, 1'b0, LAT, 1'b1));
    vecs.push_back(mk("max_q", 64'hFFFF_FFFE * 64'hFFFF_FFFE + 64'hFFFF_FFFD,
                      32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, LAT, 1'b1));
    vecs.push_back(mk("1000_div_10", 64'd1000, 32'd10, 32'd100, 32'd0, 1'b0, LAT, 1'b1));
    vecs.push_back(mk("zero_div_1", 64'd0, 32'd1, 32'd0, 32'd0, 1'b0, LAT, 1'b1));
    vecs.push_back(mk("ones_div_1", 64'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, LAT, 1'b1));
    vecs.push_back(mk("2p32_div_2", 64'h1_0000_0000, 32'd2, 32'h8000_0000, 32'd0, 1'b0, LAT, 1'b1));
    vecs.push_back(mk("12345678_div_1000", 64'd12345678, 32'd1000, 32'd12345, 32'd678, 1'b0, LAT, 1'b1));
`ifdef RCA_DIV_ERR_CHECK_EN
    vecs.push_back(mk("div_by_zero", 64'd55, 32'd0, 32'hFFFF_FFFF, 32'd55, 1'b1, 1, 1'b1));
    vecs.push_back(mk("overflow", 64'h5_0000_0000, 32'd5, 32'hFFFF_FFFF, 32'd0, 1'b1, 1, 1'b1));
`else
    vecs.push_back(mk("overflow_nochk", 64'h5_0000_0000, 32'd5, 32'd0, 32'd0, 1'b0, LAT, 1'b0));
`endif

    // Reset state
    rst_n = 1'b0;
    bus.in_div_start    = 1'b0;
    bus.in_div_dividend = '0;
    bus.in_div_divisor  = '0;
    #12;
    check("rst/busy", 64'(bus.out_div_busy), 64'(0));
    check("rst/done", 64'(bus.out_div_done), 64'(0));
    check("rst/err", 64'(bus.out_div_err), 64'(0));
    check("rst/quotient", 64'(bus.out_div_quotient), 64'(0));
    check("rst/remainder", 64'(bus.out_div_remainder), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Start with new operands during RUN is ignored.
    drive_start(64'd100, 32'd7);
    repeat (3) @(negedge clk);
    bus.in_div_dividend = 64'd999;
    bus.in_div_divisor  = 32'd3;
    bus.in_div_start    = 1'b1;
    repeat (2) @(negedge clk);
    bus.in_div_start = 1'b0;
    wait_done(seen, lat, busy_cnt);
    check("run_start/done_seen", 64'(seen), 64'(1));
    check("run_start/latency", 64'(lat), 64'(LAT - 5));
    check("run_start/quotient", 64'(bus.out_div_quotient), 64'(14));
    check("run_start/remainder", 64'(bus.out_div_remainder), 64'(2));
    @(negedge clk);

    // Start held high through DONE: second operation with no idle gap.
    bus.in_div_dividend = 64'd100;
    bus.in_div_divisor  = 32'd7;
    bus.in_div_start    = 1'b1;
    @(posedge clk);
    #1;
    bus.in_div_dividend = 64'd1000;
    bus.in_div_divisor  = 32'd10;
    wait_done(seen, lat, busy_cnt);
    check("b2b_first/done_seen", 64'(seen), 64'(1));
    check("b2b_first/latency", 64'(lat), 64'(LAT));
    check("b2b_first/quotient", 64'(bus.out_div_quotient), 64'(14));
    check("b2b_first/remainder", 64'(bus.out_div_remainder), 64'(2));
    @(posedge clk);
    #1 bus.in_div_start = 1'b0;
    @(negedge clk);
    check("b2b_second/busy_no_gap", 64'(bus.out_div_busy), 64'(1));
    check("b2b_second/done_low", 64'(bus.out_div_done), 64'(0));
    wait_done(seen, lat, busy_cnt);
    check("b2b_second/done_seen", 64'(seen), 64'(1));
    check("b2b_second/latency", 64'(lat), 64'(LAT - 1));
    check("b2b_second/quotient", 64'(bus.out_div_quotient), 64'(100));
    check("b2b_second/remainder", 64'(bus.out_div_remainder), 64'(0));
    @(negedge clk);

    // Asynchronous reset in the middle of RUN.
    drive_start(64'd100, 32'd7);
    repeat (10) @(negedge clk);
    check("mid_rst/busy_before", 64'(bus.out_div_busy), 64'(1));
    rst_n = 1'b0;
    #1;
    check("mid_rst/busy", 64'(bus.out_div_busy), 64'(0));
    check("mid_rst/done", 64'(bus.out_div_done), 64'(0));
    check("mid_rst/err", 64'(bus.out_div_err), 64'(0));
    check("mid_rst/quotient", 64'(bus.out_div_quotient), 64'(0));
    check("mid_rst/remainder", 64'(bus.out_div_remainder), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    repeat (W + 5) begin
      @(negedge clk);
      if (bus.out_div_done || bus.out_div_busy) done_cnt++;
    end
    check("mid_rst/no_activity_after", 64'(done_cnt), 64'(0));
    run_vec(mk("after_rst_1000_div_10", 64'd1000, 32'd10, 32'd100, 32'd0, 1'b0, LAT, 1'b1));

    // Sweep: dividend built as q*d + r with r < d, so q and r are exact.
    for (int i = 0; i < 50; i++) begin
      rd = $urandom;
      if (rd == 0) rd = 32'd1;
      rq = $urandom;
      rr = $urandom % rd;
      run_vec(mk($sformatf("sweep%0d", i), 64'(rq) * 64'(rd) + 64'(rr),
                 rd, rq, rr, 1'b0, LAT, 1'b1));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rca_div.md
# rca_div

Sequential restoring integer divider: the inverse companion of the shift-and-add multiplier `rca_mult`. It accepts a 2·DATA_WIDTH-bit dividend, such as a product from `rca_mult`, and a DATA_WIDTH-bit divisor. It produces a DATA_WIDTH-bit quotient and remainder, one bit per clock. It sits beside the multiplier in the sequential arithmetic datapath and is driven by a start/done handshake.

## Interface
- DATA_WIDTH, 32, divisor/quotient/remainder width; dividend is 2·DATA_WIDTH.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_div_start  in  1  request; sampled only in IDLE or DONE
- in_div_dividend  in  2·DATA_WIDTH  unsigned dividend, sampled with start
- in_div_divisor  in  DATA_WIDTH  unsigned divisor, sampled with start
- out_div_busy  out  1  high while in RUN
- out_div_done  out  1  one-cycle pulse when results are valid
- out_div_quotient  out  DATA_WIDTH  quotient, held until the next accepted start
- out_div_remainder  out  DATA_WIDTH  remainder, held until the next accepted start
- out_div_err  out  1  divide-by-zero or quotient overflow, held with the results

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE; all outputs 0.
- IDLE/DONE with start=1 (edge t0):
  - Latch the operands.
  - Partial remainder ← dividend[2W-1:W]; shift register ← dividend[W-1:0]; step counter ← 0.
  - Go to RUN; busy=1.
- Error check (compiled in): at t0, divisor==0 or dividend[2W-1:W] ≥ divisor.
  - Skip RUN and go straight to DONE.
  - quotient = all ones; remainder = dividend[W-1:0]; err=1.
- RUN, each edge (one restoring step):
  - Shift {rem, sreg} left 1; rem is W+1 bits wide to hold the carry-out.
  - If rem ≥ divisor: subtract divisor and shift in quotient bit 1; else shift in 0.
  - Counter increments; after W steps go to DONE.
  - Latch quotient and remainder (rem[W-1:0]); err=0; busy=0; done=1.
- DONE lasts one cycle, then IDLE. Start is accepted in DONE for back-to-back operation.
- Start while in RUN is ignored; the operation continues unaffected.
- Input changes outside the start edge have no effect.
- Postcondition (no err): dividend == quotient·divisor + remainder, and remainder < divisor.

## Timing
- Normal latency: start at edge t0 → done high in the cycle after edge t0+W. Busy is high for cycles t0..t0+W-1.
- Error latency: done high in the cycle after edge t0; busy never asserts.
- done is exactly one cycle wide.
- Back-to-back throughput: one result per W+1 cycles.
- Asynchronous reset mid-RUN: state → IDLE; busy, done, err, quotient, remainder → 0 immediately; no done pulse follows.
- Outputs are registered; there are no combinational input→output paths.

## Configuration
- Macro RCA_DIV_ERR_CHECK_EN.
- Defined: divide-by-zero/overflow detection and the fast path to DONE, as above.
- Undefined:
  - No checking; out_div_err tied 0.
  - Every start runs the full W steps with normal latency.
  - Quotient and remainder are unspecified for divisor 0 or dividend[2W-1:W] ≥ divisor.

## Structure
- Package rca_arith_pkg: the state enum (IDLE/RUN/DONE) and a counter-width constant, $clog2(DATA_WIDTH+1). The package is shared with future sequential arithmetic blocks.
- Sub-module rca_div_step: combinational single restoring step.
  - Inputs: W+1-bit remainder, incoming dividend bit, divisor.
  - Outputs: next remainder, quotient bit.
- The top module holds the FSM, counter and registers.

## Test plan
- dividend 100, divisor 7 → quotient 14, remainder 2, err 0; done exactly at t0+W+1; busy high W cycles.
- dividend (2^32−2)·(2^32−2)+(2^32−3), divisor 2^32−2 → quotient 2^32−2, remainder 2^32−3.
- divisor 0, dividend 55 (with macro) → done at t0+1, err 1, quotient 0xFFFFFFFF, remainder 55.
- dividend 5·2^32, divisor 5 → err 1; without the macro → done at t0+W+1, err 0.
- Start re-asserted with new operands during RUN → ignored; the original result (100/7) is delivered. Start held high in DONE → second operation accepted with no idle gap.
- rst_n low at t0+10 → outputs 0 at once, no done pulse; a following start of 1000/10 → quotient 100, remainder 0.
- Randomized sweep of 50 operands: quotient·divisor+remainder == dividend.
